// File: rtl/alu_mult_sequencer.sv
// Shift-add multiplier controller that borrows the shared ALU_LEGv8 datapath for every add and shift.
// Optional early termination is enabled by defining MULT_EARLY_TERM_EN.
module alu_mult_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] SHF  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] FS_IDLE = 5'b00000;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SHL  = 5'b10000;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mplier_shr;
  logic             accept;

  assign mplier_shr = mplier >> 1;
  assign accept     = in_valid && in_ready;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = in_b[0] ? ADD : SHF;
          if (EARLY_TERM && (in_b == '0)) state_nxt = DONE;
        end
      end
      ADD:  state_nxt = SHF;
      SHF: begin
        if (cnt == LAST_CNT)                        state_nxt = DONE;
        else if (EARLY_TERM && (mplier_shr == '0))  state_nxt = DONE;
        else                                        state_nxt = mplier_shr[0] ? ADD : SHF;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state and registers only; reset state is IDLE, so only in_ready needs the reset gate.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_product = '0;
    alu_A       = '0;
    alu_B       = '0;
    alu_FS      = FS_IDLE;
    alu_C0      = 1'b0;
    case (state)
      IDLE: in_ready = reset;
      ADD: begin
        alu_A  = acc;
        alu_B  = mcand;
        alu_FS = FS_ADD;
      end
      SHF: begin
        alu_A  = mcand;
        alu_B  = WIDTH'(1);
        alu_FS = FS_SHL;
      end
      DONE: begin
        out_valid   = 1'b1;
        out_product = acc;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= in_a;
            mplier <= in_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ADD: acc <= alu_F;
        SHF: begin
          mcand  <= alu_F;
          mplier <= mplier_shr;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer: behavioural ALU model, product/latency scoreboard,
// back-pressure, mid-operation reset and ALU encoding legality.
module tb_alu_mult_sequencer;

  localparam int WIDTH = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_product;
  logic [WIDTH-1:0] alu_A, alu_B, alu_F;
  logic [4:0]       alu_FS;
  logic             alu_C0;

  alu_mult_sequencer #(.WIDTH(WIDTH), .CNT_W(7)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_C0(alu_C0), .alu_F(alu_F)
  );

  always #5 clock = ~clock;

  // Behavioural LEGv8 ALU: FS[0] inverts A, FS[1] inverts B, FS[4:2] selects the operation.
  logic [WIDTH-1:0] a_op, b_op;
  always_comb begin
    a_op = alu_FS[0] ? ~alu_A : alu_A;
    b_op = alu_FS[1] ? ~alu_B : alu_B;
    case (alu_FS[4:2])
      3'b000:  alu_F = a_op & b_op;
      3'b001:  alu_F = a_op | b_op;
      3'b010:  alu_F = a_op + b_op + WIDTH'(alu_C0);
      3'b011:  alu_F = a_op ^ b_op;
      3'b100:  alu_F = alu_A << alu_B[5:0];
      3'b101:  alu_F = alu_A >> alu_B[5:0];
      default: alu_F = 'x;
    endcase
  end

  int add_total = 0;
  int shf_total = 0;
  int illegal   = 0;
  always @(negedge clock) begin
    if (alu_FS == 5'b01000) add_total++;
    if (alu_FS == 5'b10000) shf_total++;
    if (alu_FS[4:3] == 2'b11 || alu_C0 !== 1'b0) illegal++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] prod;
    int               lat;
  } exp_t;
  exp_t sb[$];

  // Clock edges after the accept edge until out_valid is visible.
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
    int pc;
    pc = $countones(b);
`ifdef MULT_EARLY_TERM_EN
    begin
      int hi;
      if (b == '0) return 0;  // DONE is entered on the accept edge itself
      hi = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
      return hi + 1 + pc;
    end
`else
    return WIDTH + pc;
`endif
  endfunction

  int last_adds;

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    exp_t e;
    int   lat, adds0, w;
    logic got;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    check("ready_before_op", 64'(in_ready), 64'd1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    e.prod    = a * b;
    e.lat     = exp_lat(b);
    sb.push_back(e);
    adds0     = add_total;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clock);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clock);
        lat++;
      end
    end
    check("out_valid_seen", 64'(got), 64'd1);
    last_adds = add_total - adds0;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("product", out_product, e.prod);
      check("latency", 64'(lat), 64'(e.lat));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1 in_valid = i[0];
      in_b = '1;
      @(negedge clock);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_product", out_product, a * b);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    if (hold != 0) @(posedge clock);
    @(negedge clock);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_product"},   out_product, 64'd0);
    check({tag, "_alu_A"},     alu_A, 64'd0);
    check({tag, "_alu_B"},     alu_B, 64'd0);
    check({tag, "_alu_FS"},    64'(alu_FS), 64'd0);
    check({tag, "_alu_C0"},    64'(alu_C0), 64'd0);
  endtask

  initial begin
    #3 check_all_zero("reset");
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);

    run_op(64'd3, 64'd5, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    check("wrap_add_count", 64'(last_adds), 64'd1);
    run_op(64'h1234, 64'd0, 0);
    check("zero_add_count", 64'(last_adds), 64'd0);
    run_op(64'h1_0000_0000, 64'h1_0000_0000, 0);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 0);
    run_op({$urandom, $urandom}, 64'h8000_0000_0000_0001, 0);
    run_op(64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0000_0000_0BCD, 10);

    // Abort an operation once the shift counter has reached 20.
    begin
      int s0, w;
      in_a      = 64'h55;
      in_b      = 64'h8000_0000_0000_0003;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      s0 = shf_total;
      w  = 0;
      while ((shf_total - s0) < 21 && w < 300) begin
        @(negedge clock);
        w++;
      end
      check("reach_cnt20", 64'(shf_total - s0), 64'd21);
      #2 reset = 1'b0;
      #1 check_all_zero("midop_reset");
      @(posedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      check("post_reset_no_valid", 64'(out_valid), 64'd0);
    end

    run_op(64'd7, 64'd6, 0);

    check("alu_encoding_legal", 64'(illegal), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
